// File: rtl/nw_pkg.sv
// Shared types and scoring constants for the Needleman-Wunsch score-matrix stage.
package nw_pkg;

  // Scoring scheme
  localparam int MATCH    = 1;
  localparam int MISMATCH = -1;
  localparam int GAP      = -2;

  // Nucleotide codes
  localparam logic [1:0] NT_A = 2'd0;
  localparam logic [1:0] NT_C = 2'd1;
  localparam logic [1:0] NT_G = 2'd2;
  localparam logic [1:0] NT_T = 2'd3;

  // Traceback direction
  typedef enum logic [1:0] {
    DIR_DIAG = 2'b00,
    DIR_UP   = 2'b01,
    DIR_LEFT = 2'b10,
    DIR_NONE = 2'b11
  } dir_e;

  // Cell scorer FSM
  typedef enum logic [2:0] {
    StIdle,
    StRdD,
    StRdU,
    StRdL,
    StCalc,
    StWrite
  } state_e;

endpackage

// File: rtl/nw_cell_scorer_if.sv
// Request/result handshake plus score-RAM port of one cell scorer.
interface nw_cell_scorer_if #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned IDX_W  = 4
);
  logic                     start;
  logic [IDX_W-1:0]         i;
  logic [IDX_W-1:0]         j;
  logic [1:0]               char_a;
  logic [1:0]               char_b;
  logic                     busy;
  logic                     done;
  logic [1:0]               dir;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [DATA_W-1:0] wr_data;

  // Requester and RAM side
  modport master (
    output start, i, j, char_a, char_b, rd_data,
    input  busy, done, dir, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  // Cell scorer side
  modport slave (
    input  start, i, j, char_a, char_b, rd_data,
    output busy, done, dir, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/max3_dir.sv
// Three-way maximum with D > U > L tie priority and signed saturation to DATA_W bits.
module max3_dir
  import nw_pkg::*;
#(
  parameter int unsigned DATA_W = 9
) (
  input  logic signed [DATA_W:0]   c_d,
  input  logic signed [DATA_W:0]   c_u,
  input  logic signed [DATA_W:0]   c_l,
  output logic signed [DATA_W-1:0] score,
  output dir_e                     dir
);

  localparam logic signed [DATA_W:0] SatMax = {2'b00, {(DATA_W - 1){1'b1}}};
  localparam logic signed [DATA_W:0] SatMin = {2'b11, {(DATA_W - 1){1'b0}}};

  logic signed [DATA_W:0] best;

  // Pick the winner (>= keeps the earlier candidate on ties), then clamp
  always_comb begin
    best = c_d;
    dir  = DIR_DIAG;
    if (c_d >= c_u && c_d >= c_l) begin
      best = c_d;
      dir  = DIR_DIAG;
    end else if (c_u >= c_l) begin
      best = c_u;
      dir  = DIR_UP;
    end else begin
      best = c_l;
      dir  = DIR_LEFT;
    end

    if (best > SatMax) begin
      score = SatMax[DATA_W-1:0];
    end else if (best < SatMin) begin
      score = SatMin[DATA_W-1:0];
    end else begin
      score = best[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/nw_cell_scorer.sv
// Scores one Needleman-Wunsch matrix cell: reads D/U/L neighbours, picks the max, writes back.
module nw_cell_scorer
  import nw_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned DATA_W = 9,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned IDX_W  = 4
) (
  input logic            clk,
  input logic            rst,
  nw_cell_scorer_if.slave bus
);

  localparam logic signed [DATA_W:0] MatchW    = (DATA_W + 1)'(MATCH);
  localparam logic signed [DATA_W:0] MismatchW = (DATA_W + 1)'(MISMATCH);
  localparam logic signed [DATA_W:0] GapW      = (DATA_W + 1)'(GAP);
  localparam logic [IDX_W-1:0]       One       = IDX_W'(1);

  // Row-major address of cell (r, c)
  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] r,
                                                input logic [IDX_W-1:0] c);
    int a;
    a = int'(r) * int'(N + 1) + int'(c);
    return ADDR_W'(a);
  endfunction

  state_e state_q, state_d;

  logic [IDX_W-1:0]         i_q, j_q;
  logic [1:0]               char_a_q, char_b_q;
  logic signed [DATA_W-1:0] s_d_q, s_u_q;

  logic                     rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]        rd_addr_q, rd_addr_d;
  logic                     wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic signed [DATA_W-1:0] wr_data_q, wr_data_d;
  dir_e                     dir_q, dir_d;
  logic                     done_q, done_d;
  logic                     busy_q, busy_d;

  logic                     interior;
  logic [IDX_W-1:0]         idx_max;
  logic signed [DATA_W-1:0] init_score;
  dir_e                     init_dir;

  logic signed [DATA_W:0]   c_d, c_u, c_l;
  logic signed [DATA_W-1:0] best_score;
  dir_e                     best_dir;

  // Init-cell value and direction, decoded straight from the request inputs
  always_comb begin
    interior   = (bus.i != '0) && (bus.j != '0);
    idx_max    = (bus.i > bus.j) ? bus.i : bus.j;
    // |GAP * N| fits DATA_W for legal parameters, so no clamp is needed here
    init_score = DATA_W'(GAP * int'(idx_max));
    if (bus.i == '0 && bus.j == '0) begin
      init_dir = DIR_NONE;
    end else if (bus.i == '0) begin
      init_dir = DIR_LEFT;
    end else begin
      init_dir = DIR_UP;
    end
  end

  // Candidate scores at DATA_W+1 bits; sL comes straight off the RAM in CALC
  always_comb begin
    c_d = {s_d_q[DATA_W-1], s_d_q} + ((char_a_q == char_b_q) ? MatchW : MismatchW);
    c_u = {s_u_q[DATA_W-1], s_u_q} + GapW;
    c_l = {bus.rd_data[DATA_W-1], bus.rd_data} + GapW;
  end

  max3_dir #(
    .DATA_W (DATA_W)
  ) u_max3_dir (
    .c_d   (c_d),
    .c_u   (c_u),
    .c_l   (c_l),
    .score (best_score),
    .dir   (best_dir)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = interior ? StRdD : StWrite;
      StRdD:   state_d = StRdU;
      StRdU:   state_d = StRdL;
      StRdL:   state_d = StCalc;
      StCalc:  state_d = StWrite;
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs, keyed on the transition being taken
  always_comb begin
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    busy_d    = (state_d != StIdle);
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (interior) begin
            rd_en_d   = 1'b1;
            rd_addr_d = addr_of(bus.i - One, bus.j - One);
          end else begin
            wr_en_d   = 1'b1;
            done_d    = 1'b1;
            wr_addr_d = addr_of(bus.i, bus.j);
            wr_data_d = init_score;
            dir_d     = init_dir;
          end
        end
      end
      StRdD: begin
        rd_en_d   = 1'b1;
        rd_addr_d = addr_of(i_q - One, j_q);
      end
      StRdU: begin
        rd_en_d   = 1'b1;
        rd_addr_d = addr_of(i_q, j_q - One);
      end
      StCalc: begin
        wr_en_d   = 1'b1;
        done_d    = 1'b1;
        wr_addr_d = addr_of(i_q, j_q);
        wr_data_d = best_score;
        dir_d     = best_dir;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      dir_q     <= DIR_NONE;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  // Request latch and neighbour-score capture (data arrives one state after its read)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_q      <= '0;
      j_q      <= '0;
      char_a_q <= '0;
      char_b_q <= '0;
      s_d_q    <= '0;
      s_u_q    <= '0;
    end else begin
      if (state_q == StIdle && bus.start) begin
        i_q      <= bus.i;
        j_q      <= bus.j;
        char_a_q <= bus.char_a;
        char_b_q <= bus.char_b;
      end
      if (state_q == StRdU) s_d_q <= bus.rd_data;
      if (state_q == StRdL) s_u_q <= bus.rd_data;
    end
  end

  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.dir     = dir_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_nw_cell_scorer.sv
// Scoreboard bench for nw_cell_scorer with a behavioural synchronous score RAM.
module tb_nw_cell_scorer;
  import nw_pkg::*;

  localparam int DW = 9;

  typedef struct {
    int addr;
    int data;
    int dir;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  exp_t sb[$];
  int   exp_rd[$];

  logic signed [DW-1:0] mem [128];

  nw_cell_scorer_if #(.DATA_W(9), .ADDR_W(7), .IDX_W(4)) bus ();

  nw_cell_scorer #(
    .N      (8),
    .DATA_W (9),
    .ADDR_W (7),
    .IDX_W  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Synchronous score RAM: one-cycle read latency
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    if (bus.wr_en) mem[bus.wr_addr] = bus.wr_data;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int a_of(input int r, input int c);
    return r * 9 + c;
  endfunction

  // Reference scoring: plain integer math, explicit priority and clamp
  function automatic void model(input int sd, input int su, input int sl, input bit m,
                                output int sc, output int d);
    int cd, cu, cl;
    cd = sd + (m ? 1 : -1);
    cu = su - 2;
    cl = sl - 2;
    if (cd >= cu && cd >= cl) begin
      sc = cd; d = 0;
    end else if (cu >= cl) begin
      sc = cu; d = 1;
    end else begin
      sc = cl; d = 2;
    end
    if (sc > 255) sc = 255;
    if (sc < -256) sc = -256;
  endfunction

  // Monitor: read addresses, write results, rd/wr exclusivity
  always @(negedge clk) begin
    if (bus.rd_en) begin
      check_eq("rd_wr_excl", int'(bus.wr_en), 0);
      if (exp_rd.size() == 0) check_eq("rd_unexpected", 1, 0);
      else check_eq("rd_addr", int'(bus.rd_addr), exp_rd.pop_front());
    end
    if (bus.done) begin
      exp_t e;
      done_cnt++;
      check_eq("wr_en_with_done", int'(bus.wr_en), 1);
      if (sb.size() == 0) begin
        check_eq("done_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check_eq("wr_addr", int'(bus.wr_addr), e.addr);
        check_eq("wr_data", int'(bus.wr_data), e.data);
        check_eq("dir", int'(bus.dir), e.dir);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rd_en"}, int'(bus.rd_en), 0);
    check_eq({tag, "_wr_en"}, int'(bus.wr_en), 0);
    check_eq({tag, "_done"}, int'(bus.done), 0);
    check_eq({tag, "_busy"}, int'(bus.busy), 0);
    check_eq({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
    check_eq({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
    check_eq({tag, "_wr_data"}, int'(bus.wr_data), 0);
    check_eq({tag, "_dir"}, int'(bus.dir), 3);
  endtask

  // Issue one cell, push expectations, wait (bounded) for done and check latency
  task automatic run_cell(input int ci, input int cj, input logic [1:0] ca,
                          input logic [1:0] cb, input bit poke);
    exp_t e;
    int   lat, start_cyc, d0;
    bit   got;
    e.addr = a_of(ci, cj);
    if (ci == 0 || cj == 0) begin
      e.data = -2 * ((ci > cj) ? ci : cj);
      e.dir  = (ci == 0 && cj == 0) ? 3 : (ci == 0) ? 2 : 1;
      lat    = 1;
    end else begin
      model(int'(mem[a_of(ci - 1, cj - 1)]), int'(mem[a_of(ci - 1, cj)]),
            int'(mem[a_of(ci, cj - 1)]), (ca == cb), e.data, e.dir);
      exp_rd.push_back(a_of(ci - 1, cj - 1));
      exp_rd.push_back(a_of(ci - 1, cj));
      exp_rd.push_back(a_of(ci, cj - 1));
      lat = 5;
    end
    sb.push_back(e);
    d0 = done_cnt;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.i      = 4'(ci);
    bus.j      = 4'(cj);
    bus.char_a = ca;
    bus.char_b = cb;
    start_cyc  = cyc;
    got        = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start = 1'b0;
        check_eq("busy_set", int'(bus.busy), 1);
      end
      if (poke && k == 3) begin
        bus.start = 1'b1;
        bus.i     = 4'd0;
        bus.j     = 4'd0;
      end
      if (poke && k == 4) bus.start = 1'b0;
      if (bus.done) begin
        got = 1'b1;
        check_eq("latency", cyc - start_cyc, lat);
      end
    end
    if (!got) check_eq("done_timeout", 0, 1);
    repeat (4) @(negedge clk);
    check_eq("busy_clear", int'(bus.busy), 0);
    check_eq("one_done", done_cnt - d0, 1);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.i       = '0;
    bus.j       = '0;
    bus.char_a  = NT_A;
    bus.char_b  = NT_A;
    bus.rd_data = '0;
    for (int k = 0; k < 128; k++) mem[k] = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    @(negedge clk);

    // Interior match
    mem[0] = 9'sd0; mem[1] = -9'sd2; mem[9] = -9'sd2;
    run_cell(1, 1, NT_G, NT_G, 1'b0);

    // Mismatch with D/U tie
    mem[11] = -9'sd3; mem[12] = -9'sd2; mem[20] = -9'sd6;
    run_cell(2, 3, NT_A, NT_C, 1'b0);

    // Init cells
    run_cell(0, 0, NT_A, NT_T, 1'b0);
    run_cell(0, 5, NT_A, NT_T, 1'b0);
    run_cell(4, 0, NT_C, NT_G, 1'b0);

    // Up wins
    mem[41] = -9'sd10; mem[42] = 9'sd0; mem[51] = -9'sd5;
    run_cell(5, 6, NT_T, NT_T, 1'b0);

    // Left wins
    mem[46] = -9'sd10; mem[47] = -9'sd10; mem[56] = 9'sd3;
    run_cell(6, 2, NT_A, NT_G, 1'b0);

    // Positive saturation
    mem[60] = 9'sd255; mem[61] = 9'sd0; mem[69] = 9'sd0;
    run_cell(7, 7, NT_C, NT_C, 1'b0);

    // Negative saturation with a start pulse during RD_L
    mem[20] = -9'sd256; mem[21] = -9'sd256; mem[29] = -9'sd256;
    run_cell(3, 3, NT_A, NT_C, 1'b1);

    // Reset while in RD_U: no write may follow
    begin
      int d0;
      d0 = done_cnt;
      exp_rd.push_back(a_of(0, 0));
      exp_rd.push_back(a_of(0, 1));
      exp_rd.push_back(a_of(1, 0));
      @(negedge clk);
      bus.start = 1'b1;
      bus.i     = 4'd1;
      bus.j     = 4'd1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_rd.delete();
      sb.delete();
      @(negedge clk);
      check_reset_outputs("mid_rst");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (6) @(negedge clk);
      check_eq("no_partial_write", done_cnt - d0, 0);
    end

    // Normal operation after reset
    mem[0] = 9'sd0; mem[1] = -9'sd2; mem[9] = -9'sd2;
    run_cell(1, 1, NT_T, NT_T, 1'b0);

    check_eq("sb_drained", sb.size(), 0);
    check_eq("rd_drained", exp_rd.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
